// File: rtl/regf_mem_arb.sv
// regf_mem_arb: round-robin arbiter and sequencer in front of a register
// file's mem_* port. NUM_REQ requesters share one bus and only one access
// is in flight at a time. The block also issues a one-cycle soft-reset
// pulse into the regf, but only once no access is in flight.
//
// Ports:
//   main_clk_i, main_rst_i       clock, async active-high reset
//   req_i/addr_i/wena_i/wdata_i  per-requester request (slice k = [k*W +: W])
//   ack_o/rdata_o/err_o          one-hot completion pulse + response data
//   mem_ena_o/mem_addr_o/
//   mem_wena_o/mem_wdata_o       to regf mem port
//   mem_rdata_i/mem_err_i        from regf, valid 1 cycle after mem_ena_o
//   soft_rst_req_i, soft_rst_o   soft-reset request in, pulse out to regf
//   busy_o                       FSM not in IDLE
module regf_mem_arb #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 13,
  parameter int DW      = 32
) (
  input  logic                  main_clk_i,
  input  logic                  main_rst_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*AW-1:0] addr_i,
  input  logic [NUM_REQ-1:0]    wena_i,
  input  logic [NUM_REQ*DW-1:0] wdata_i,
  output logic [NUM_REQ-1:0]    ack_o,
  output logic [DW-1:0]         rdata_o,
  output logic                  err_o,
  output logic                  mem_ena_o,
  output logic [AW-1:0]         mem_addr_o,
  output logic                  mem_wena_o,
  output logic [DW-1:0]         mem_wdata_o,
  input  logic [DW-1:0]         mem_rdata_i,
  input  logic                  mem_err_i,
  input  logic                  soft_rst_req_i,
  output logic                  soft_rst_o,
  output logic                  busy_o
);

  localparam int SW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, SRST} state_t;

  state_t             state, state_nx;
  logic [SW-1:0]      rr_last, sel, win;
  logic [SW:0]        rr_sum;
  logic [NUM_REQ-1:0] mask;
  logic               win_vld, grant, soft_pend;

  // Requesters eligible this cycle. In RESP the just-acked requester is
  // masked out so a held req_i cannot win twice in a row.
  always_comb begin
    mask = req_i;
    if (state == RESP) mask[sel] = 1'b0;
  end

  // Search rr_last+1, rr_last+2, ... modulo NUM_REQ; first set bit wins.
  // One extra sum bit keeps the wrap correct for non-power-of-2 NUM_REQ.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    rr_sum  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_sum = {1'b0, rr_last} + (SW+1)'(i);
      if (rr_sum >= (SW+1)'(NUM_REQ)) rr_sum = rr_sum - (SW+1)'(NUM_REQ);
      if (!win_vld && mask[rr_sum[SW-1:0]]) begin
        win_vld = 1'b1;
        win     = rr_sum[SW-1:0];
      end
    end
  end

  // Next state. A pending soft reset is taken only from IDLE/RESP, so an
  // access already issued always completes and acks first.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    case (state)
      IDLE: begin
        if (soft_pend) state_nx = SRST;
        else if (win_vld) begin
          grant    = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT:  state_nx = RESP;
      RESP: begin
        if (soft_pend) state_nx = SRST;
        else if (win_vld) begin
          grant    = 1'b1;
          state_nx = ISSUE;
        end else state_nx = IDLE;
      end
      SRST:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) state <= IDLE;
    else            state <= state_nx;
  end

  // Registered outputs. mem_* request fields load only on a grant so they
  // hold between accesses; rdata/err load only in WAIT.
  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) begin
      rr_last     <= SW'(NUM_REQ-1);
      sel         <= '0;
      soft_pend   <= 1'b0;
      ack_o       <= '0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      mem_ena_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wena_o  <= 1'b0;
      mem_wdata_o <= '0;
      soft_rst_o  <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      // a request arriving in the SRST cycle wins over the clear (re-arm)
      soft_pend  <= soft_rst_req_i | (soft_pend & (state != SRST));
      busy_o     <= (state_nx != IDLE);
      soft_rst_o <= (state_nx == SRST);
      mem_ena_o  <= grant;
      ack_o      <= '0;
      if (grant) begin
        sel         <= win;
        rr_last     <= win;
        mem_addr_o  <= addr_i[win*AW +: AW];
        mem_wena_o  <= wena_i[win];
        mem_wdata_o <= wena_i[win] ? wdata_i[win*DW +: DW] : '0;
      end
      if (state == WAIT) begin
        rdata_o    <= mem_rdata_i;
        err_o      <= mem_err_i;
        ack_o[sel] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regf_mem_arb.sv
module tb_regf_mem_arb;
  localparam int NR = 2, AW = 13, DW = 32;

  logic             clk = 1'b0, rst = 1'b1;
  logic [NR-1:0]    req = '0, wena = '0, ack;
  logic [NR*AW-1:0] addr = '0;
  logic [NR*DW-1:0] wdata = '0;
  logic [DW-1:0]    rdata, mem_wdata, mem_rdata = '0;
  logic [AW-1:0]    mem_addr;
  logic             err, mem_ena, mem_wena, mem_err = 1'b0;
  logic             soft_req = 1'b0, soft_rst, busy;

  int tests = 0, fails = 0;

  regf_mem_arb #(.NUM_REQ(NR), .AW(AW), .DW(DW)) dut (
    .main_clk_i(clk), .main_rst_i(rst),
    .req_i(req), .addr_i(addr), .wena_i(wena), .wdata_i(wdata),
    .ack_o(ack), .rdata_o(rdata), .err_o(err),
    .mem_ena_o(mem_ena), .mem_addr_o(mem_addr), .mem_wena_o(mem_wena),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .soft_rst_req_i(soft_req), .soft_rst_o(soft_rst), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    tick; tick;
    chk("rst_outs", {ack, mem_ena, busy, soft_rst, err, mem_wena}, 0);
    chk("rst_data", {rdata, mem_addr, mem_wdata}, 0);
    rst = 1'b0;

    // RR fairness: both held, reads; wdata0 nonzero but reads must drive 0
    addr  = {13'h0020, 13'h0010};
    wdata = {32'h0, 32'hDEADBEEF};
    mem_rdata = 32'h0000_1111;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("rr_ena",   mem_ena, 1);
      chk("rr_addr",  mem_addr, (k % 2) ? 13'h0020 : 13'h0010);
      chk("rr_wdata", mem_wdata, 0);
      tick;
      chk("rr_ack_early", {mem_ena, ack}, 0);
      tick;
      chk("rr_ack", ack, (k % 2) ? 2'b10 : 2'b01);
      if (k == 3) req = 2'b00;
    end
    tick;
    chk("rr_idle", {busy, ack, mem_ena}, 0);

    // single read: rr_last=1, so requester 0 wins
    addr = {13'h0000, 13'h0004};
    mem_rdata = 32'hCAFE0001;
    req = 2'b01;
    tick;
    chk("rd_ena",  {mem_ena, mem_wena, busy}, 3'b101);
    chk("rd_addr", mem_addr, 13'h0004);
    tick;
    chk("rd_t2", {mem_ena, ack}, 0);
    tick;
    chk("rd_ack",   ack, 2'b01);
    chk("rd_rdata", rdata, 32'hCAFE0001);
    chk("rd_err",   err, 0);
    req = 2'b00;
    tick;
    chk("rd_done", {ack, busy}, 0);

    // error path: write from requester 1
    addr  = {13'h1FFC, 13'h0000};
    wdata = {32'h12345678, 32'h0};
    wena  = 2'b10;
    mem_rdata = 32'h0;
    mem_err = 1'b1;
    req = 2'b10;
    tick;
    chk("wr_ena",   {mem_ena, mem_wena}, 2'b11);
    chk("wr_addr",  mem_addr, 13'h1FFC);
    chk("wr_wdata", mem_wdata, 32'h12345678);
    tick; tick;
    chk("wr_ack", {ack, err}, 3'b101);
    req = 2'b00;
    mem_err = 1'b0;
    tick;
    chk("wr_hold", {err, mem_ena, mem_addr}, {2'b10, 13'h1FFC});

    // soft reset requested during ISSUE with both requesting
    wena = 2'b00;
    addr = {13'h0022, 13'h0011};
    req = 2'b11;
    tick;
    chk("sr_grant0", mem_addr, 13'h0011);
    soft_req = 1'b1;
    tick;
    soft_req = 1'b0;
    tick;
    chk("sr_ack", {ack, soft_rst}, 3'b010);
    tick;
    chk("sr_pulse", {soft_rst, ack, mem_ena, busy}, 5'b10001);
    tick;
    chk("sr_end", {soft_rst, busy}, 0);
    tick;
    chk("sr_next", {mem_ena, mem_addr}, {1'b1, 13'h0022});

    // reset while in WAIT
    tick;
    rst = 1'b1;
    #1;
    chk("mr_async", {ack, mem_ena, busy, mem_addr, rdata, err}, 0);
    tick;
    chk("mr_noack", {ack, soft_rst}, 0);
    rst = 1'b0;
    tick;
    chk("mr_first", {mem_ena, mem_addr}, {1'b1, 13'h0011});
    tick; tick;
    chk("mr_ack", ack, 2'b01);
    req = 2'b00;
    tick;

    // soft reset from IDLE, re-armed in its own SRST cycle
    soft_req = 1'b1;
    tick;
    soft_req = 1'b0;
    tick;
    chk("sr2_pulse", soft_rst, 1);
    soft_req = 1'b1;
    tick;
    soft_req = 1'b0;
    chk("sr2_gap", soft_rst, 0);
    tick;
    chk("sr2_rearm", soft_rst, 1);
    tick;
    chk("sr2_end", {soft_rst, busy}, 0);

    // idle: nothing moves for 100 cycles
    for (int k = 0; k < 100; k++) begin
      tick;
      chk("idle", {mem_ena, busy, ack}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
